systolic_array_ws: RTL and testbench

Parametrised weight-stationary systolic matrix-vector engine, the successor to the fixed 128×128 crossbar PE array. It computes y = aᵀ·W for a ROWS×COLS weight tile and a stream of activation vectors. It provides:
- a weight-load phase;
- internal input skew and output de-skew;
- valid/ready handshakes with full-pipeline backpressure;
- a signed/unsigned mode.

It sits between the activation/weight SRAM readers and the accumulator/writeback stage.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_mac_pe.sv | 52 +++++
 rtl/systolic_array_ws.sv | 216 +++++++++++++++++++++
 tb/tb_systolic_array_ws.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and elaboration helpers for the weight-stationary systolic array.
// Holds the controller state encoding, lane-slicing helpers and the accumulator width check.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN
  } state_t;

  // Bit offset of a lane inside a flattened multi-lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic bit accum_width_ok(input int data_width, input int accum_width);
    return accum_width >= 2 * data_width;
  endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// One processing element: stationary weight, activation pass-through to the right,
// and multiply-add of the incoming partial sum passed downward.
module systolic_mac_pe #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   adv,
  input  logic                   signed_mode,
  input  logic                   w_we,
  input  logic [DATA_WIDTH-1:0]  w_in,
  input  logic [DATA_WIDTH-1:0]  a_in,
  input  logic [ACCUM_WIDTH-1:0] psum_in,
  output logic [DATA_WIDTH-1:0]  a_out,
  output logic [ACCUM_WIDTH-1:0] psum_out
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0]  w_reg;
  logic [DATA_WIDTH-1:0]  a_reg;
  logic [ACCUM_WIDTH-1:0] psum_reg;
  logic signed [PW-1:0]   prod_s;
  logic [PW-1:0]          prod_u;
  logic [ACCUM_WIDTH-1:0] prod_ext;

  // Full-width product in either interpretation; mode picks sign or zero extension.
  assign prod_s   = PW'($signed(a_in)) * PW'($signed(w_reg));
  assign prod_u   = PW'(a_in) * PW'(w_reg);
  assign prod_ext = signed_mode ? ACCUM_WIDTH'(prod_s) : ACCUM_WIDTH'(prod_u);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_reg    <= '0;
      a_reg    <= '0;
      psum_reg <= '0;
    end else begin
      if (w_we) begin
        w_reg <= w_in;
      end
      if (adv) begin
        a_reg    <= a_in;
        psum_reg <= psum_in + prod_ext;
      end
    end
  end

  assign a_out    = a_reg;
  assign psum_out = psum_reg;

endmodule

// File: rtl/systolic_array_ws.sv
// Weight-stationary ROWS x COLS matrix-vector engine computing y = a^T * W,
// with input skew, output de-skew and a single global advance for backpressure.
module systolic_array_ws
  import systolic_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [COLS*DATA_WIDTH-1:0]  w_data,
  input  logic                        signed_mode,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]  a_data,
  input  logic                        a_last,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic [COLS*ACCUM_WIDTH-1:0] y_data,
  output logic                        y_last,
  output logic                        busy
);

  localparam int DEPTH = ROWS + COLS - 1;
  localparam int RCW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (!accum_width_ok(DATA_WIDTH, ACCUM_WIDTH)) begin : g_width_check
    $error("systolic_array_ws: ACCUM_WIDTH must be at least 2*DATA_WIDTH");
  end

  state_t                    state_reg;
  logic [RCW-1:0]            row_cnt_reg;
  logic                      mode_reg;
  logic                      w_ready_reg;
  logic                      busy_reg;
  logic                      stream_reg;
  logic                      y_valid_reg;
  logic                      y_last_reg;
  logic [COLS*ACCUM_WIDTH-1:0] y_data_reg;
  logic [DEPTH-1:0]          vld_reg;
  logic [DEPTH-1:0]          lst_reg;

  logic                      adv;
  logic                      w_fire;
  logic                      a_fire;
  logic                      y_fire;
  logic [ROWS*DATA_WIDTH-1:0]  a_in_vec;
  logic [COLS*ACCUM_WIDTH-1:0] y_next;
  logic [ROWS-1:0]           row_we;

  logic [DATA_WIDTH-1:0]     a_h [ROWS][COLS];
  logic [ACCUM_WIDTH-1:0]    ps [ROWS+1][COLS];
  logic [DATA_WIDTH-1:0]     a_unused [ROWS];

  assign adv      = !y_valid_reg || y_ready;
  assign w_fire   = w_valid && w_ready_reg;
  assign a_ready  = stream_reg && adv;
  assign a_fire   = a_valid && a_ready;
  assign y_fire   = y_valid_reg && y_ready;
  // Cycles without an accepted vector push zero activations as bubbles.
  assign a_in_vec = a_fire ? a_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      row_cnt_reg <= '0;
      mode_reg    <= 1'b0;
      w_ready_reg <= 1'b1;
      busy_reg    <= 1'b0;
      stream_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (w_fire) begin
            mode_reg <= signed_mode;
            busy_reg <= 1'b1;
            if (ROWS == 1) begin
              state_reg   <= STREAM;
              w_ready_reg <= 1'b0;
              stream_reg  <= 1'b1;
            end else begin
              state_reg   <= LOAD_W;
              row_cnt_reg <= RCW'(1);
            end
          end
        end
        LOAD_W: begin
          if (w_fire) begin
            if (row_cnt_reg == RCW'(ROWS - 1)) begin
              state_reg   <= STREAM;
              row_cnt_reg <= '0;
              w_ready_reg <= 1'b0;
              stream_reg  <= 1'b1;
            end else begin
              row_cnt_reg <= row_cnt_reg + RCW'(1);
            end
          end
        end
        STREAM: begin
          if (a_fire && a_last) begin
            state_reg  <= DRAIN;
            stream_reg <= 1'b0;
          end
        end
        DRAIN: begin
          if (y_fire && y_last_reg) begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            w_ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Row skew: row i is delayed by i advances before entering column 0.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [DATA_WIDTH-1:0] a_lane;
    assign a_lane     = a_in_vec[lane_lo(gi, DATA_WIDTH) +: DATA_WIDTH];
    assign row_we[gi] = w_fire && (row_cnt_reg == RCW'(gi));
    if (gi == 0) begin : g_direct
      assign a_h[gi][0] = a_lane;
    end else begin : g_skew
      logic [DATA_WIDTH-1:0] skew_reg [gi];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < gi; k++) skew_reg[k] <= '0;
        end else if (adv) begin
          skew_reg[0] <= a_lane;
          for (int k = 1; k < gi; k++) skew_reg[k] <= skew_reg[k-1];
        end
      end
      assign a_h[gi][0] = skew_reg[gi-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_pe_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe_col
      logic [DATA_WIDTH-1:0] a_nxt;
      systolic_mac_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACCUM_WIDTH(ACCUM_WIDTH)
      ) u_pe (
        .clk        (clk),
        .reset      (reset),
        .adv        (adv),
        .signed_mode(mode_reg),
        .w_we       (row_we[gi]),
        .w_in       (w_data[lane_lo(gj, DATA_WIDTH) +: DATA_WIDTH]),
        .a_in       (a_h[gi][gj]),
        .psum_in    (ps[gi][gj]),
        .a_out      (a_nxt),
        .psum_out   (ps[gi+1][gj])
      );
      if (gj < COLS - 1) begin : g_pass
        assign a_h[gi][gj+1] = a_nxt;
      end else begin : g_edge
        assign a_unused[gi] = a_nxt;
      end
    end
  end

  // Column de-skew: column j waits COLS-1-j advances so every lane lines up.
  for (genvar gj = 0; gj < COLS; gj++) begin : g_col
    localparam int DD = COLS - 1 - gj;
    logic [ACCUM_WIDTH-1:0] col_out;
    assign ps[0][gj] = '0;
    if (DD == 0) begin : g_direct
      assign col_out = ps[ROWS][gj];
    end else begin : g_deskew
      logic [ACCUM_WIDTH-1:0] dsk_reg [DD];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < DD; k++) dsk_reg[k] <= '0;
        end else if (adv) begin
          dsk_reg[0] <= ps[ROWS][gj];
          for (int k = 1; k < DD; k++) dsk_reg[k] <= dsk_reg[k-1];
        end
      end
      assign col_out = dsk_reg[DD-1];
    end
    assign y_next[lane_lo(gj, ACCUM_WIDTH) +: ACCUM_WIDTH] = col_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_reg     <= '0;
      lst_reg     <= '0;
      y_valid_reg <= 1'b0;
      y_last_reg  <= 1'b0;
      y_data_reg  <= '0;
    end else if (adv) begin
      vld_reg[0] <= a_fire;
      lst_reg[0] <= a_fire && a_last;
      for (int k = 1; k < DEPTH; k++) begin
        vld_reg[k] <= vld_reg[k-1];
        lst_reg[k] <= lst_reg[k-1];
      end
      y_valid_reg <= vld_reg[DEPTH-1];
      y_last_reg  <= lst_reg[DEPTH-1];
      y_data_reg  <= y_next;
    end
  end

  assign w_ready = w_ready_reg;
  assign busy    = busy_reg;
  assign y_valid = y_valid_reg;
  assign y_last  = y_last_reg;
  assign y_data  = y_data_reg;

endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for systolic_array_ws: a 4x4 array at 20-bit accumulators alongside
// a 16-bit twin fed the same stimulus to exercise wrap-around.
module tb_systolic_array_ws;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        w_valid = 1'b0;
  logic [31:0] w_data = '0;
  logic        signed_mode = 1'b0;
  logic        a_valid = 1'b0;
  logic [31:0] a_data = '0;
  logic        a_last = 1'b0;
  logic        y_ready = 1'b1;

  logic        w_ready, a_ready, y_valid, y_last, busy;
  logic [79:0] y_data;
  logic        w_ready16, a_ready16, y_valid16, y_last16, busy16;
  logic [63:0] y_data16;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  int wm [4][4];

  systolic_array_ws #(.ROWS(4), .COLS(4), .DATA_WIDTH(8), .ACCUM_WIDTH(20)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .signed_mode(signed_mode), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .a_last(a_last), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_last(y_last), .busy(busy)
  );

  systolic_array_ws #(.ROWS(4), .COLS(4), .DATA_WIDTH(8), .ACCUM_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready16), .w_data(w_data),
    .signed_mode(signed_mode), .a_valid(a_valid), .a_ready(a_ready16), .a_data(a_data),
    .a_last(a_last), .y_valid(y_valid16), .y_ready(y_ready), .y_data(y_data16),
    .y_last(y_last16), .busy(busy16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk8(input int v[4]);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[j*8 +: 8] = v[j][7:0];
    return r;
  endfunction

  function automatic logic [79:0] pk20(input int v[4]);
    logic [79:0] r;
    for (int j = 0; j < 4; j++) r[j*20 +: 20] = v[j][19:0];
    return r;
  endfunction

  function automatic logic [63:0] pk16(input int v[4]);
    logic [63:0] r;
    for (int j = 0; j < 4; j++) r[j*16 +: 16] = v[j][15:0];
    return r;
  endfunction

  // Plain unsigned matrix-vector product against the current weight table.
  function automatic logic [79:0] model20(input int a[4]);
    logic [79:0] r;
    int s;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int i = 0; i < 4; i++) s += a[i] * wm[i][j];
      r[j*20 +: 20] = s[19:0];
    end
    return r;
  endfunction

  task automatic load_w(input bit sm);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      w_valid = 1'b1;
      signed_mode = sm;
      for (int j = 0; j < 4; j++) w_data[j*8 +: 8] = wm[r][j][7:0];
      #1;
      chk("w_ready_load", w_ready, 1);
      if (a_valid) chk("a_ready_in_load", a_ready, 0);
      @(posedge clk);
    end
    @(negedge clk);
    w_valid = 1'b0;
    a_valid = 1'b0;
    a_last = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] a, input bit last);
    int n = 0;
    @(negedge clk);
    a_valid = 1'b1;
    a_data = a;
    a_last = last;
    #1;
    while (!a_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("a_ready_accept", a_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    a_valid = 1'b0;
    a_last = 1'b0;
  endtask

  task automatic wait_y(output int lat);
    int n = 0;
    @(negedge clk);
    while (!y_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("y_valid_arrives", y_valid, 1);
    lat = cyc - acc_cyc;
  endtask

  initial begin
    int av[4];
    int ev[4];
    int lat;
    logic [31:0]  va [8];
    logic [79:0]  exp4 [8];
    logic [127:0] held;
    int n_in, n_out;
    bit stall_prev, seen;

    // Reset values
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_w_ready", w_ready, 1);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_y_last", y_last, 0);
    chk("rst_busy", busy, 0);

    // Identity weights, latency and drain back to idle
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wm[i][j] = (i == j) ? 1 : 0;
    load_w(1'b0);
    chk("busy_stream", busy, 1);
    chk("w_ready_stream", w_ready, 0);
    av = '{1, 2, 3, 4};
    send_a(pk8(av), 1'b1);
    wait_y(lat);
    chk("latency", lat, 7);
    ev = '{1, 2, 3, 4};
    chk("identity_y", y_data, pk20(ev));
    chk("identity_last", y_last, 1);
    @(posedge clk);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_w_ready", w_ready, 1);
    chk("idle_y_valid", y_valid, 0);

    // Signed: W=-128, a=-1 gives 4*128
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wm[i][j] = -128;
    load_w(1'b1);
    av = '{-1, -1, -1, -1};
    send_a(pk8(av), 1'b1);
    wait_y(lat);
    ev = '{512, 512, 512, 512};
    chk("signed_y20", y_data, pk20(ev));
    chk("signed_y16", y_data16, pk16(ev));
    @(posedge clk);

    // Unsigned 255*255*4: fits in 20 bits, wraps in 16 bits
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wm[i][j] = 255;
    load_w(1'b0);
    av = '{255, 255, 255, 255};
    send_a(pk8(av), 1'b1);
    wait_y(lat);
    ev = '{260100, 260100, 260100, 260100};
    chk("unsigned_y20", y_data, pk20(ev));
    chk("wrap_valid16", y_valid16, 1);
    ev = '{63492, 63492, 63492, 63492};
    chk("wrap_y16", y_data16, pk16(ev));
    @(posedge clk);

    // Eight back-to-back vectors under y_ready pattern 1,0,0
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wm[i][j] = i * 4 + j + 1;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) av[i] = n * 3 + i + 1;
      va[n] = pk8(av);
      exp4[n] = model20(av);
    end
    load_w(1'b0);
    n_in = 0;
    n_out = 0;
    stall_prev = 1'b0;
    held = '0;
    for (int c = 0; c < 300 && n_out < 8; c++) begin
      @(negedge clk);
      y_ready = (c % 3 == 0);
      if (n_in < 8) begin
        a_valid = 1'b1;
        a_data = va[n_in];
        a_last = (n_in == 7);
      end else begin
        a_valid = 1'b0;
        a_last = 1'b0;
      end
      #1;
      if (stall_prev) chk("y_hold", {46'd0, y_valid, y_last, y_data}, held);
      if (y_valid && !y_ready) chk("a_ready_stall", a_ready, 0);
      if (y_valid && y_ready) begin
        chk("y_seq", y_data, exp4[n_out]);
        chk("y_last_seq", y_last, (n_out == 7));
        n_out++;
      end
      if (a_valid && a_ready) n_in++;
      stall_prev = y_valid && !y_ready;
      held = {46'd0, y_valid, y_last, y_data};
    end
    chk("seq_count", n_out, 8);
    a_valid = 1'b0;
    a_last = 1'b0;
    y_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("seq_idle", busy, 0);

    // Stray handshakes: a_valid during load, w_valid during stream
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wm[i][j] = i + 1;
    a_valid = 1'b1;
    a_data = 32'hFFFF_FFFF;
    a_last = 1'b1;
    load_w(1'b0);
    w_valid = 1'b1;
    w_data = 32'h7777_7777;
    #1;
    chk("w_ready_in_stream", w_ready, 0);
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    av = '{1, 2, 3, 4};
    send_a(pk8(av), 1'b1);
    chk("w_ready_in_drain", w_ready, 0);
    wait_y(lat);
    ev = '{30, 30, 30, 30};
    chk("weights_kept", y_data, pk20(ev));
    @(posedge clk);

    // Reset with three vectors in flight, then reload from scratch
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wm[i][j] = (i == j) ? 1 : 0;
    load_w(1'b0);
    av = '{9, 9, 9, 9};
    for (int k = 0; k < 3; k++) send_a(pk8(av), 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_y_valid", y_valid, 0);
    chk("mid_rst_w_ready", w_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (y_valid) seen = 1'b1;
    end
    chk("no_y_after_rst", seen, 0);
    chk("idle_after_rst", {busy, w_ready}, 2'b01);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wm[i][j] = j + 1;
    load_w(1'b0);
    av = '{1, 1, 1, 1};
    send_a(pk8(av), 1'b1);
    wait_y(lat);
    ev = '{4, 8, 12, 16};
    chk("reload_y", y_data, pk20(ev));
    chk("reload_last", y_last, 1);
    @(posedge clk);
    @(negedge clk);
    chk("reload_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
